nv_tieoff_release_seq: RTL

//  Power-sequencing controller for the constant-0 tie-off sources that hold NVDLA sub-block enables/clamps inactive.

---
 rtl/nv_tieoff_release_seq_pkg.sv | 20 ++
 rtl/nv_tieoff_release_seq_if.sv | 27 ++
 rtl/nv_tieoff_release_seq_dwell_cnt.sv | 27 ++
 rtl/nv_tieoff_release_seq.sv | 132 +++++++++++++
 4 files changed

// File: rtl/nv_tieoff_release_seq_pkg.sv
// Shared definitions for the tie-off release sequencer: state encodings,
// default geometry and a small decode helper.
package nv_tieoff_release_seq_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 8;

  typedef logic [1:0] seq_state_t;

  localparam logic [1:0] SEQ_OFF = 2'd0;
  localparam logic [1:0] SEQ_UP  = 2'd1;
  localparam logic [1:0] SEQ_ON  = 2'd2;
  localparam logic [1:0] SEQ_DN  = 2'd3;

  // Busy whenever a release or clamp walk is in progress.
  function automatic logic seq_busy_f(input seq_state_t st);
    return (st == SEQ_UP) || (st == SEQ_DN);
  endfunction

endpackage

// File: rtl/nv_tieoff_release_seq_if.sv
// Handshake/status bundle between the power controller (master) and the
// tie-off sequencer (slave).
interface nv_tieoff_release_seq_if
  import nv_tieoff_release_seq_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic [CNT_W-1:0]  cfg_dwell;
  logic              pwr_up_req;
  logic              pwr_dn_req;
  logic [NUM_CH-1:0] chan_en;
  logic              seq_busy;
  logic              up_done;
  logic              dn_done;
  seq_state_t        seq_state;

  modport master (
    output cfg_dwell, pwr_up_req, pwr_dn_req,
    input  chan_en, seq_busy, up_done, dn_done, seq_state
  );

  modport slave (
    input  cfg_dwell, pwr_up_req, pwr_dn_req,
    output chan_en, seq_busy, up_done, dn_done, seq_state
  );
endinterface

// File: rtl/nv_tieoff_release_seq_dwell_cnt.sv
// Dwell down-counter: load has priority, decrement saturates at zero so the
// count can never wrap.
module nv_tieoff_dwell_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;

  // Load a fresh dwell or count down towards zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/nv_tieoff_release_seq.sv
// Tie-off release sequencer: walks the channel enables up one at a time on a
// power-up request and back down on a power-down request, with a programmable
// dwell between steps. Power-down always wins so the clamps fail safe.
module nv_tieoff_release_seq
  import nv_tieoff_release_seq_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rstn,
  nv_tieoff_release_seq_if.slave  bus
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);

  seq_state_t        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [NUM_CH-1:0] r_chan_en;
  logic              r_busy;
  logic              r_up_done;
  logic              r_dn_done;

  seq_state_t        w_state_nx;
  logic [IDX_W-1:0]  w_idx_nx;
  logic [NUM_CH-1:0] w_chan_nx;
  logic              w_up_done_nx;
  logic              w_dn_done_nx;
  logic              w_load;
  logic              w_dec;
  logic              w_zero;
  logic [IDX_W-1:0]  w_idx_inc;
  logic [IDX_W-1:0]  w_idx_dec;

  assign w_idx_inc = r_idx + 1'b1;
  assign w_idx_dec = r_idx - 1'b1;

  nv_tieoff_dwell_cnt #(.CNT_W(CNT_W)) u_dwell (
    .i_clk      (nvdla_core_clk),
    .i_rst_n    (nvdla_core_rstn),
    .i_load     (w_load),
    .i_load_val (bus.cfg_dwell),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // Next-state decode: one enable bit changes per step, so chan_en stays a thermometer code.
  always_comb begin
    w_state_nx   = r_state;
    w_idx_nx     = r_idx;
    w_chan_nx    = r_chan_en;
    w_up_done_nx = 1'b0;
    w_dn_done_nx = 1'b0;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    case (r_state)
      SEQ_OFF: begin
        if (bus.pwr_up_req && !bus.pwr_dn_req) begin
          w_state_nx   = SEQ_UP;
          w_idx_nx     = '0;
          w_chan_nx[0] = 1'b1;
          w_load       = 1'b1;
        end
      end
      SEQ_UP: begin
        if (bus.pwr_dn_req) begin
          // Abort in place: start clamping from the highest released channel.
          w_state_nx       = SEQ_DN;
          w_chan_nx[r_idx] = 1'b0;
          w_load           = 1'b1;
        end else if (!w_zero) begin
          w_dec = 1'b1;
        end else if (r_idx != LAST) begin
          w_idx_nx             = w_idx_inc;
          w_chan_nx[w_idx_inc] = 1'b1;
          w_load               = 1'b1;
        end else begin
          w_state_nx   = SEQ_ON;
          w_up_done_nx = 1'b1;
        end
      end
      SEQ_ON: begin
        if (bus.pwr_dn_req) begin
          w_state_nx      = SEQ_DN;
          w_idx_nx        = LAST;
          w_chan_nx[LAST] = 1'b0;
          w_load          = 1'b1;
        end
      end
      SEQ_DN: begin
        if (!w_zero) begin
          w_dec = 1'b1;
        end else if (r_idx != '0) begin
          w_idx_nx             = w_idx_dec;
          w_chan_nx[w_idx_dec] = 1'b0;
          w_load               = 1'b1;
        end else begin
          w_state_nx   = SEQ_OFF;
          w_dn_done_nx = 1'b1;
        end
      end
      default: begin
        w_state_nx = SEQ_OFF;
      end
    endcase
  end

  // Register state, index, enables and status so every output is a flop.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_state   <= SEQ_OFF;
      r_idx     <= '0;
      r_chan_en <= '0;
      r_busy    <= 1'b0;
      r_up_done <= 1'b0;
      r_dn_done <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_idx     <= w_idx_nx;
      r_chan_en <= w_chan_nx;
      r_busy    <= seq_busy_f(w_state_nx);
      r_up_done <= w_up_done_nx;
      r_dn_done <= w_dn_done_nx;
    end
  end

  assign bus.chan_en   = r_chan_en;
  assign bus.seq_busy  = r_busy;
  assign bus.up_done   = r_up_done;
  assign bus.dn_done   = r_dn_done;
  assign bus.seq_state = r_state;
endmodule
